// File: rtl/res_pkg.sv
// Shared constants and types for the residual-add stream block.
// FP16 encodings, mode encoding and FSM state type.
package res_pkg;

    localparam int DATA_WIDTH = 16;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_PINF = 16'h7C00;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_BYP = 1'b1;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

endpackage

// File: rtl/res_add_stream_if.sv
// Generic valid/ready/data stream bundle.
// master drives valid/data, slave drives ready.
interface res_add_stream_if #(
    parameter int W = 64
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/floatAdd.sv
// Combinational IEEE half-precision adder, round-to-nearest-even.
// NaN in -> quiet NaN, inf-inf -> NaN, overflow -> signed inf.
module floatAdd
    import res_pkg::*;
(
    input  logic [15:0] floatA,
    input  logic [15:0] floatB,
    output logic [15:0] sum
);

    logic        a_nan, b_nan, a_inf, b_inf;
    logic        swap, sub, sticky, zero_r, rnd;
    logic [15:0] big, sml;
    logic [4:0]  eb, es, d, p;
    logic [10:0] gb, gs;
    logic [23:0] sh_ext, sh_val, lost_mask;
    logic [24:0] s;
    logic [6:0]  e, lsh;
    logic [11:0] m;

    always_comb begin
        a_nan = (&floatA[14:10]) && (|floatA[9:0]);
        b_nan = (&floatB[14:10]) && (|floatB[9:0]);
        a_inf = (&floatA[14:10]) && !(|floatA[9:0]);
        b_inf = (&floatB[14:10]) && !(|floatB[9:0]);
        swap  = floatA[14:0] < floatB[14:0];
        big   = swap ? floatB : floatA;
        sml   = swap ? floatA : floatB;
        sub   = big[15] ^ sml[15];
        eb    = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
        es    = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
        gb    = {|big[14:10], big[9:0]};
        gs    = {|sml[14:10], sml[9:0]};
        d     = eb - es;
        // 13 extra low bits hold guard/round; anything lower is sticky
        sh_ext    = {gs, 13'b0};
        lost_mask = '0;
        if (d > 5'd23) begin
            sh_val = '0;
            sticky = |gs;
        end else begin
            sh_val    = sh_ext >> d;
            lost_mask = (24'd1 << d) - 24'd1;
            sticky    = |(sh_ext & lost_mask);
        end
        sh_val = sh_val | {23'b0, sticky};
        if (sub)
            s = {1'b0, gb, 13'b0} - {1'b0, sh_val};
        else
            s = {1'b0, gb, 13'b0} + {1'b0, sh_val};
        zero_r = (s == 25'd0);
        e      = {2'b0, eb};
        p      = '0;
        for (int i = 0; i < 25; i++)
            if (s[i]) p = 5'(i);
        lsh = '0;
        if (s[24]) begin
            s = {1'b0, s[24:1]} | {24'b0, s[0]};
            e = e + 7'd1;
        end else if (p < 5'd23) begin
            lsh = 7'(5'd23 - p);
            if (lsh > e - 7'd1) lsh = e - 7'd1;
            s = s << lsh;
            e = e - lsh;
        end
        m   = {1'b0, s[23:13]};
        rnd = s[12] && ((|s[11:0]) || m[0]);
        m   = m + {11'b0, rnd};
        if (m[11]) begin
            m = m >> 1;
            e = e + 7'd1;
        end
        if (a_nan || b_nan)
            sum = FP16_QNAN;
        else if (a_inf && b_inf)
            sum = sub ? FP16_QNAN : big;
        else if (a_inf)
            sum = floatA;
        else if (b_inf)
            sum = floatB;
        else if (zero_r)
            sum = {floatA[15] & floatB[15], 15'b0};
        else if (m[10] && e >= 7'd31)
            sum = {big[15], FP16_PINF[14:0]};
        else
            sum = {big[15], m[10] ? e[4:0] : 5'd0, m[9:0]};
    end

endmodule

// File: rtl/res_skip_fifo.sv
// Shortcut buffer: synchronous first-word-fall-through FIFO.
// Push through a stream slave port; head is visible while non-empty.
module res_skip_fifo #(
    parameter  int W     = 64,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    res_add_stream_if.slave wr,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full, push, pop_ok;

    always_comb begin
        full     = (level_q == LW'(DEPTH));
        empty    = (level_q == '0);
        wr.ready = !full;
        push     = wr.valid && !full;
        pop_ok   = pop && !empty;
        rd_data  = mem_q[rd_ptr_q];
        level    = level_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        unique case ({push, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr.data;
    end

endmodule

// File: rtl/res_add_stream.sv
// Residual add: joins the buffered shortcut stream with the conv stream,
// lane-wise FP16 add (or conv bypass), framed output with out_last.
module res_add_stream
    import res_pkg::*;
#(
    parameter  int LANES       = 4,
    parameter  int SKIP_DEPTH  = 64,
    parameter  int FRAME_BEATS = 16,
    localparam int W           = LANES * DATA_WIDTH,
    localparam int LW          = $clog2(SKIP_DEPTH + 1),
    localparam int CW          = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mode,
    input  logic          sc_valid,
    output logic          sc_ready,
    input  logic [W-1:0]  sc_data,
    input  logic          cv_valid,
    output logic          cv_ready,
    input  logic [W-1:0]  cv_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic [LW-1:0] fifo_level
);

    state_e        state_q, state_d;
    logic          mode_q, mode_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [W-1:0]  head, sum_w;
    logic          empty, join_go, pop, last_beat;

    res_add_stream_if #(.W(W)) push_if ();

    assign push_if.valid = sc_valid && reset && (mode_q == MODE_ADD);
    assign push_if.data  = sc_data;
    assign sc_ready      = reset && (mode_q == MODE_ADD) && push_if.ready;

    res_skip_fifo #(.W(W), .DEPTH(SKIP_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (push_if),
        .pop     (pop),
        .rd_data (head),
        .empty   (empty),
        .level   (fifo_level)
    );

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        floatAdd u_add (
            .floatA (cv_data[i*16 +: 16]),
            .floatB (head[i*16 +: 16]),
            .sum    (sum_w[i*16 +: 16])
        );
    end

    always_comb begin
        join_go = reset && cv_valid
                  && ((mode_q == MODE_BYP) || !empty)
                  && (!out_valid_q || out_ready);
        pop       = join_go && (mode_q == MODE_ADD);
        cv_ready  = join_go;
        last_beat = (beat_cnt_q == CW'(FRAME_BEATS - 1));
        state_d     = state_q;
        mode_d      = mode_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (join_go) begin
            out_valid_d = 1'b1;
            out_data_d  = (mode_q == MODE_BYP) ? cv_data : sum_w;
            out_last_d  = last_beat;
            beat_cnt_d  = last_beat ? '0 : beat_cnt_q + CW'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        // mode is frozen from the first join until the frame's last join
        unique case (state_q)
            IDLE: begin
                if (!join_go)
                    mode_d = mode;
                else if (!last_beat)
                    state_d = RUN;
            end
            RUN: begin
                if (join_go && last_beat) begin
                    state_d = IDLE;
                    mode_d  = mode;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            mode_q      <= MODE_ADD;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_res_add_stream.sv
// Directed bench for res_add_stream: add, skew, full FIFO,
// backpressure, framing with mode change, mid-frame reset.
module tb_res_add_stream;
    import res_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       mode0, mode1;
    logic       last0, last1;
    logic [6:0] lvl0;
    logic [2:0] lvl1;
    int         total = 0;
    int         bad   = 0;

    res_add_stream_if #(.W(64)) sc0 ();
    res_add_stream_if #(.W(64)) cv0 ();
    res_add_stream_if #(.W(64)) o0 ();
    res_add_stream_if #(.W(64)) sc1 ();
    res_add_stream_if #(.W(64)) cv1 ();
    res_add_stream_if #(.W(64)) o1 ();

    res_add_stream #(.LANES(4), .SKIP_DEPTH(64), .FRAME_BEATS(16)) dut0 (
        .clk(clk), .reset(reset), .mode(mode0),
        .sc_valid(sc0.valid), .sc_ready(sc0.ready), .sc_data(sc0.data),
        .cv_valid(cv0.valid), .cv_ready(cv0.ready), .cv_data(cv0.data),
        .out_valid(o0.valid), .out_ready(o0.ready), .out_data(o0.data),
        .out_last(last0), .fifo_level(lvl0)
    );

    res_add_stream #(.LANES(4), .SKIP_DEPTH(4), .FRAME_BEATS(16)) dut1 (
        .clk(clk), .reset(reset), .mode(mode1),
        .sc_valid(sc1.valid), .sc_ready(sc1.ready), .sc_data(sc1.data),
        .cv_valid(cv1.valid), .cv_ready(cv1.ready), .cv_data(cv1.data),
        .out_valid(o1.valid), .out_ready(o1.ready), .out_data(o1.data),
        .out_last(last1), .fifo_level(lvl1)
    );

    function automatic logic [63:0] lanes4(input logic [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [63:0] skew_beat(input int k);
        logic [63:0] v;
        for (int i = 0; i < 4; i++)
            v[i*16 +: 16] = 16'(16'h4000 + k * 16 + i);
        return v;
    endfunction

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sc0.valid = 0; cv0.valid = 0; o0.ready = 1;
        sc1.valid = 0; cv1.valid = 0; o1.ready = 1;
        sc0.data = '0; cv0.data = '0; sc1.data = '0; cv1.data = '0;
        mode0 = 0; mode1 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        cyc();
        cyc();
        reset = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        sc0.valid = 1; cv0.valid = 1;
        sc0.data = lanes4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        cyc();
        cyc();
        total++;
        if (sc0.ready !== 1'b0) begin
            bad++; $display("FAIL rst_sc_ready got=%b want=0", sc0.ready);
        end
        total++;
        if (cv0.ready !== 1'b0) begin
            bad++; $display("FAIL rst_cv_ready got=%b want=0", cv0.ready);
        end
        total++;
        if (lvl0 !== 7'd0) begin
            bad++; $display("FAIL rst_level got=%0d want=0", lvl0);
        end
        total++;
        if ({o0.valid, last0} !== 2'b00) begin
            bad++; $display("FAIL rst_valid_last got=%b want=00", {o0.valid, last0});
        end
        total++;
        if (o0.data !== 64'd0) begin
            bad++; $display("FAIL rst_data got=%h want=0", o0.data);
        end
        reset = 1;
        sc0.valid = 0; cv0.valid = 0;
        #1;
        total++;
        if (sc0.ready !== 1'b1) begin
            bad++; $display("FAIL post_rst_sc_ready got=%b want=1", sc0.ready);
        end
    endtask

    task automatic test_add();
        logic [63:0] exp_v;
        exp_v = lanes4(16'h4000, 16'h0000, 16'h4200, 16'h3C00);
        cyc();
        sc0.valid = 1;
        sc0.data = lanes4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        cyc();
        sc0.valid = 0;
        total++;
        if (lvl0 !== 7'd1) begin
            bad++; $display("FAIL add_level got=%0d want=1", lvl0);
        end
        cv0.valid = 1;
        cv0.data = lanes4(16'h3C00, 16'hBC00, 16'h4000, 16'h0000);
        #1;
        total++;
        if (cv0.ready !== 1'b1) begin
            bad++; $display("FAIL add_cv_ready got=%b want=1", cv0.ready);
        end
        cyc();
        cv0.valid = 0;
        total++;
        if (o0.valid !== 1'b1 || o0.data !== exp_v) begin
            bad++;
            $display("FAIL add_out got=%b/%h want=1/%h", o0.valid, o0.data, exp_v);
        end
        total++;
        if (lvl0 !== 7'd0) begin
            bad++; $display("FAIL add_pop got=%0d want=0", lvl0);
        end
        cyc();
        total++;
        if (o0.valid !== 1'b0) begin
            bad++; $display("FAIL add_drain got=%b want=0", o0.valid);
        end
    endtask

    task automatic test_skew();
        for (int k = 0; k < 10; k++) begin
            cyc();
            sc0.valid = 1;
            sc0.data = skew_beat(k);
        end
        cyc();
        sc0.valid = 0;
        total++;
        if (lvl0 !== 7'd10) begin
            bad++; $display("FAIL skew_level got=%0d want=10", lvl0);
        end
        for (int n = 0; n < 3; n++) begin
            cyc();
            total++;
            if (o0.valid !== 1'b0 || lvl0 !== 7'd10) begin
                bad++;
                $display("FAIL skew_idle got=%b/%0d want=0/10", o0.valid, lvl0);
            end
        end
        cv0.data = '0;
        for (int n = 0; n <= 10; n++) begin
            cyc();
            if (n >= 1) begin
                total++;
                if (o0.valid !== 1'b1 || o0.data !== skew_beat(n - 1)) begin
                    bad++;
                    $display("FAIL skew_beat%0d got=%b/%h want=1/%h",
                             n - 1, o0.valid, o0.data, skew_beat(n - 1));
                end
            end
            cv0.valid = (n < 10);
        end
        cyc();
        total++;
        if (lvl0 !== 7'd0 || o0.valid !== 1'b0) begin
            bad++; $display("FAIL skew_end got=%0d/%b want=0/0", lvl0, o0.valid);
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            cyc();
            sc1.valid = 1;
            sc1.data = 64'(k + 1);
        end
        cyc();
        sc1.data = 64'd5;
        #1;
        total++;
        if (lvl1 !== 3'd4 || sc1.ready !== 1'b0) begin
            bad++; $display("FAIL full_4 got=%0d/%b want=4/0", lvl1, sc1.ready);
        end
        cyc();
        total++;
        if (lvl1 !== 3'd4 || sc1.ready !== 1'b0) begin
            bad++; $display("FAIL full_hold got=%0d/%b want=4/0", lvl1, sc1.ready);
        end
        cv1.valid = 1;
        cv1.data = '0;
        cyc();
        cv1.valid = 0;
        total++;
        if (lvl1 !== 3'd3 || sc1.ready !== 1'b1) begin
            bad++; $display("FAIL full_join got=%0d/%b want=3/1", lvl1, sc1.ready);
        end
        total++;
        if (o1.valid !== 1'b1 || o1.data !== 64'd1) begin
            bad++; $display("FAIL full_head got=%b/%h want=1/1", o1.valid, o1.data);
        end
        cyc();
        sc1.valid = 0;
        total++;
        if (lvl1 !== 3'd4) begin
            bad++; $display("FAIL full_fifth got=%0d want=4", lvl1);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] v1, v2, v3;
        v1 = lanes4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        v2 = lanes4(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        v3 = lanes4(16'h4200, 16'h4200, 16'h4200, 16'h4200);
        for (int k = 0; k < 3; k++) begin
            cyc();
            sc0.valid = 1;
            sc0.data = v1;
        end
        cyc();
        sc0.valid = 0;
        total++;
        if (lvl0 !== 7'd3) begin
            bad++; $display("FAIL bp_level got=%0d want=3", lvl0);
        end
        o0.ready = 0;
        cv0.valid = 1;
        cv0.data = v1;
        for (int n = 0; n < 5; n++) begin
            cyc();
            cv0.data = v2;
            #1;
            total++;
            if (o0.valid !== 1'b1 || o0.data !== v2 || cv0.ready !== 1'b0
                || lvl0 !== 7'd2) begin
                bad++;
                $display("FAIL bp_stall%0d got=%b/%h/%b/%0d want=1/%h/0/2",
                         n, o0.valid, o0.data, cv0.ready, lvl0, v2);
            end
        end
        cyc();
        o0.ready = 1;
        #1;
        total++;
        if (cv0.ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got=%b want=1", cv0.ready);
        end
        cyc();
        cv0.valid = 0;
        total++;
        if (o0.data !== v3 || lvl0 !== 7'd1) begin
            bad++; $display("FAIL bp_next got=%h/%0d want=%h/1", o0.data, lvl0, v3);
        end
        cyc();
        total++;
        if (o0.valid !== 1'b0) begin
            bad++; $display("FAIL bp_drain got=%b want=0", o0.valid);
        end
    endtask

    task automatic test_framing();
        int          idx;
        int          guard;
        logic [63:0] exp_v;
        logic        exp_l;
        idx = 0;
        guard = 0;
        sc0.data = lanes4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        cv0.data = lanes4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        sc0.valid = 1;
        cv0.valid = 1;
        while (idx < 32 && guard < 100) begin
            cyc();
            guard++;
            if (o0.valid === 1'b1) begin
                exp_v = (idx < 16) ? lanes4(16'h4000, 16'h4000, 16'h4000, 16'h4000)
                                   : lanes4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
                exp_l = (idx == 15) || (idx == 31);
                total++;
                if (o0.data !== exp_v || last0 !== exp_l) begin
                    bad++;
                    $display("FAIL frame_beat%0d got=%h/%b want=%h/%b",
                             idx, o0.data, last0, exp_v, exp_l);
                end
                idx++;
                if (idx == 5) mode0 = 1;
            end
        end
        sc0.valid = 0;
        cv0.valid = 0;
        total++;
        if (idx != 32) begin
            bad++; $display("FAIL frame_timeout got=%0d want=32", idx);
        end
        #1;
        total++;
        if (lvl0 !== 7'd1 || sc0.ready !== 1'b0) begin
            bad++; $display("FAIL frame_bypass_fifo got=%0d/%b want=1/0", lvl0, sc0.ready);
        end
        mode0 = 0;
    endtask

    task automatic test_reset_mid();
        int idx;
        int guard;
        sc0.data = lanes4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        cv0.data = lanes4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        cyc();
        sc0.valid = 1;
        cv0.valid = 1;
        repeat (5) cyc();
        cv0.valid = 0;
        repeat (2) cyc();
        total++;
        if (lvl0 !== 7'd3) begin
            bad++; $display("FAIL mid_level got=%0d want=3", lvl0);
        end
        sc0.valid = 0;
        reset = 0;
        cyc();
        reset = 1;
        total++;
        if (lvl0 !== 7'd0 || o0.valid !== 1'b0) begin
            bad++; $display("FAIL mid_clear got=%0d/%b want=0/0", lvl0, o0.valid);
        end
        sc0.valid = 1;
        cv0.valid = 1;
        idx = 0;
        guard = 0;
        while (idx < 16 && guard < 60) begin
            cyc();
            guard++;
            if (o0.valid === 1'b1) begin
                total++;
                if (last0 !== (idx == 15)) begin
                    bad++;
                    $display("FAIL mid_last%0d got=%b want=%b", idx, last0, idx == 15);
                end
                idx++;
            end
        end
        sc0.valid = 0;
        cv0.valid = 0;
        total++;
        if (idx != 16) begin
            bad++; $display("FAIL mid_timeout got=%0d want=16", idx);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        test_reset();
        test_add();
        do_reset();
        test_full();
        test_skew();
        do_reset();
        test_backpressure();
        do_reset();
        test_framing();
        do_reset();
        test_reset_mid();
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/res_add_stream.md
RES_ADD_STREAM -- requirements
Module: res_add_stream

Interface
REQ-001 SHALL have parameter LANES, default 4: FP16 channels carried per beat.
REQ-002 SHALL have parameter SKIP_DEPTH, default 64: shortcut FIFO depth in beats; power of two, at least 2.
REQ-003 SHALL have parameter FRAME_BEATS, default 16: beats per frame (H*W*D/LANES).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port mode, input, 1 bit: 0 = residual add, 1 = bypass (conv path only).
REQ-007 SHALL have ports sc_valid (input, 1), sc_ready (output, 1) and sc_data (input, LANES*16): the shortcut (x) stream.
REQ-008 SHALL have ports cv_valid (input, 1), cv_ready (output, 1) and cv_data (input, LANES*16): the conv-path (CBS chain) stream.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, LANES*16) and out_last (output, 1): the result stream.
REQ-010 SHALL have port fifo_level, output, $clog2(SKIP_DEPTH+1) bits: current shortcut FIFO occupancy.
REQ-011 SHALL pack lane i of every data bus in bits [i*16 +: 16], MSB-first per lane, IEEE half precision.

Function
REQ-012 SHALL accept a shortcut beat into the FIFO when sc_valid and sc_ready are both 1.
REQ-013 SHALL drive sc_ready = (mode_q==0) and FIFO not full.
REQ-014 SHALL define join = cv_valid and (mode_q==1 or FIFO non-empty) and (out_valid==0 or out_ready==1).
REQ-015 SHALL drive cv_ready = join; in add mode, join SHALL also pop one FIFO entry.
REQ-016 SHALL, on join in add mode, register out_data lane i = fp16_add(cv lane i, fifo-head lane i), with a latency of 1 cycle.
REQ-017 SHALL, on join in bypass mode, register out_data = cv_data unchanged; the FIFO is neither written nor read in bypass mode.
REQ-018 SHALL hold out_valid, out_data and out_last stable while out_valid is 1 and out_ready is 0.
REQ-019 SHALL leave fifo_level unchanged on a same-cycle push and pop, and allow no push when full and no pop when empty.
REQ-020 SHALL count joins with beat_cnt (0..FRAME_BEATS-1); out_last SHALL be 1 on the join with beat_cnt==FRAME_BEATS-1, after which beat_cnt wraps to 0.
REQ-021 SHALL implement an FSM with states IDLE and RUN.
REQ-022 SHALL, in IDLE, latch mode into mode_q every cycle.
REQ-023 SHALL transition IDLE->RUN on the first join.
REQ-024 SHALL transition RUN->IDLE on the join that asserts out_last.
REQ-025 SHALL ignore changes to mode while in RUN.
REQ-026 SHALL produce adder results with round-to-nearest-even, inf/NaN propagation and zero result for x+(-x); overflow SHALL saturate to ±inf.

Reset
REQ-027 SHALL, on reset==0 at a clock edge, clear FIFO pointers, fifo_level, beat_cnt, out_valid, out_last and out_data to 0, and set state to IDLE with mode_q=0.
REQ-028 SHALL, during reset, drive sc_ready=0 and cv_ready=0.
REQ-029 SHALL, on reset asserted mid-frame, discard all buffered beats and the partial frame; the first post-reset join starts a new frame at beat 0.

Structure
REQ-030 SHALL take DATA_WIDTH=16, the FP16 constants (ZERO 0x0000, ONE 0x3C00, PINF 0x7C00) and the mode encoding from shared package res_pkg.
REQ-031 SHALL implement the shortcut buffer as sub-module res_skip_fifo: synchronous, first-word-fall-through, LANES*16 wide, SKIP_DEPTH deep.
REQ-032 SHALL reuse the existing floatAdd combinationally, one instance per lane, feeding the output register.

Verification
REQ-033 SHALL test add mode: LANES=4, shortcut lanes 0x3C00, conv lanes 0x3C00/0xBC00/0x4000/0x0000 -> out 0x4000/0x0000/0x4200/0x3C00 one cycle after join.
REQ-034 SHALL test skew: push 10 shortcut beats before any conv beat -> fifo_level=10, cv-less cycles produce no output, and 10 conv beats drain to level 0 in order.
REQ-035 SHALL test a full FIFO: SKIP_DEPTH=4, 4 pushes -> sc_ready=0; a fifth sc_valid is held off; one join -> sc_ready=1 the next cycle.
REQ-036 SHALL test backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data is stable, cv_ready=0 and no FIFO pop occurs.
REQ-037 SHALL test framing: FRAME_BEATS=16, mode toggled mid-frame -> out_last on beat 15 only, and the new mode applies from beat 0 of the next frame.
REQ-038 SHALL test reset: reset=0 for one cycle with fifo_level=3 mid-frame -> fifo_level=0, out_valid=0, and the next frame's out_last falls 16 beats later.
